dot_product_mxn: RTL

Parametrised successor to the fixed 16×int8 dot-product engine: computes SUM a[j]*b[j] over a streamed vector `a` (M elements of N bits per beat) against a vector `b` pre-loaded into an on-chip B-store. Adds element width, lane count, and store depth as parameters, a per-product base address for multiple resident `b` vectors, a signed/unsigned mode, input bubbles via `i_valid`, and overflow/protocol error reporting. It sits between the fabric data source and the result collector.

---
 rtl/dot_product_pkg.sv | 30 +++
 rtl/dot_product_mxn_if.sv | 33 +++
 rtl/dot_product_bstore.sv | 28 ++
 rtl/dot_product_mxn.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// Shared types, constants and width helpers for the parametrised dot-product engine.
package dot_product_pkg;

  // Fixed latency from beat acceptance to o_valid.
  localparam int unsigned L = 4;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } state_e;

  // Per-beat control that travels alongside the datapath.
  typedef struct packed {
    logic valid;  // beat contributes to the accumulator
    logic first;  // beat loads rather than adds
    logic last;   // beat closes the product
    logic sgn;    // two's complement mode of the product
  } ctrl_t;

  // Width of the adder-tree output: one 2N-bit product per lane plus log2(M) growth bits.
  function automatic int unsigned tree_width(input int unsigned n, input int unsigned m);
    return 2 * n + $clog2(m);
  endfunction

  // Narrowest accumulator that still holds one full beat with a bit to spare.
  function automatic int unsigned min_sum_width(input int unsigned n, input int unsigned m);
    return tree_width(n, m) + 1;
  endfunction

endpackage

// File: rtl/dot_product_mxn_if.sv
// Beat, B-store write and result signals of the dot-product engine.
interface dot_product_mxn_if #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 16,
  parameter int unsigned A = 10,
  parameter int unsigned S = 48
) ();

  logic [M*N-1:0] i_b;
  logic [A-1:0]   i_b_addr;
  logic           i_wren;
  logic [M*N-1:0] i_a;
  logic           i_valid;
  logic           i_first;
  logic           i_last;
  logic [A-1:0]   i_base;
  logic           i_signed;
  logic [S-1:0]   o_sum;
  logic           o_valid;
  logic           o_ovf;
  logic           o_err;

  modport master (
    output i_b, i_b_addr, i_wren, i_a, i_valid, i_first, i_last, i_base, i_signed,
    input  o_sum, o_valid, o_ovf, o_err
  );

  modport slave (
    input  i_b, i_b_addr, i_wren, i_a, i_valid, i_first, i_last, i_base, i_signed,
    output o_sum, o_valid, o_ovf, o_err
  );

endinterface

// File: rtl/dot_product_bstore.sv
// Simple dual-port B-vector store: one write port, one registered read port.
module dot_product_bstore #(
  parameter int unsigned W = 128,
  parameter int unsigned A = 10
) (
  input  logic         clk_i,
  input  logic         wr_en_i,
  input  logic [A-1:0] wr_addr_i,
  input  logic [W-1:0] wr_data_i,
  input  logic [A-1:0] rd_addr_i,
  output logic [W-1:0] rd_data_o
);

  logic [W-1:0] mem_q [2**A];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read; a same-cycle write to the same word is not visible (old data).
  always_ff @(posedge clk_i) begin
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/dot_product_mxn.sv
// Streamed M-lane dot product against a resident B vector, four-stage pipeline.
module dot_product_mxn
  import dot_product_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned M = 16,
  parameter int unsigned A = 10,
  parameter int unsigned S = 48
) (
  input logic              i_clk,
  input logic              i_reset,
  dot_product_mxn_if.slave dp
);

  localparam int unsigned W  = M * N;
  localparam int unsigned TW = tree_width(N, M);

  if (S < min_sum_width(N, M)) begin : g_s_check
    $error("dot_product_mxn: S is narrower than 2N+log2(M)+1");
  end

  state_e         state_q;
  logic [A-1:0]   addr_q;
  logic [A-1:0]   rd_addr;
  logic           mode_q;
  logic           mode_cur;
  logic           first_beat;
  logic           beat_ok;
  logic           beat_err;
  logic           err_q;
  ctrl_t          ctrl_in;
  ctrl_t          ctrl_q [L-1];
  logic [W-1:0]   a1_q;
  logic [W-1:0]   b1;
  logic [2*N-1:0] ax [M];
  logic [2*N-1:0] bx [M];
  logic [2*N-1:0] prod_d [M];
  logic [2*N-1:0] prod_q [M];
  logic [TW-1:0]  tree_d;
  logic [TW-1:0]  tree_q;
  logic [S-1:0]   tree_ext;
  logic [S:0]     add_full;
  logic           add_ovf;
  logic [S-1:0]   acc_d;
  logic [S-1:0]   acc_q;
  logic           ovf_d;
  logic           ovf_q;
  logic           valid_d;
  logic           valid_q;

  dot_product_bstore #(
    .W (W),
    .A (A)
  ) u_bstore (
    .clk_i     (i_clk),
    .wr_en_i   (dp.i_wren),
    .wr_addr_i (dp.i_b_addr),
    .wr_data_i (dp.i_b),
    .rd_addr_i (rd_addr),
    .rd_data_o (b1)
  );

  // Beat classification, read address and mode selection for the incoming beat.
  always_comb begin
    first_beat = dp.i_valid & dp.i_first;
    beat_ok    = dp.i_valid & (dp.i_first | (state_q == StAccum));
    // A first beat is an error only mid-product; any other beat is an error only when idle.
    beat_err   = dp.i_valid & (dp.i_first ? (state_q == StAccum) : (state_q == StIdle));
    rd_addr    = first_beat ? dp.i_base : addr_q;
    mode_cur   = first_beat ? dp.i_signed : mode_q;
    ctrl_in    = '{valid: beat_ok, first: first_beat, last: dp.i_last, sgn: mode_cur};
  end

  // Product framing FSM with address counter, latched mode and registered error pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= beat_err;
      if (beat_ok) begin
        addr_q  <= rd_addr + A'(1);
        mode_q  <= mode_cur;
        state_q <= dp.i_last ? StIdle : StAccum;
      end
    end
  end

  // Control shift register kept in step with the datapath stages.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(L) - 1; i++) begin
        ctrl_q[i] <= '0;
      end
    end else begin
      ctrl_q[0] <= ctrl_in;
      for (int i = 1; i < int'(L) - 1; i++) begin
        ctrl_q[i] <= ctrl_q[i-1];
      end
    end
  end

  // Delay the a lanes to line up with the registered B-store read.
  always_ff @(posedge i_clk) begin
    a1_q <= dp.i_a;
  end

  // Lane multipliers: extending to 2N first makes the low 2N product bits exact in both modes.
  always_comb begin
    for (int k = 0; k < int'(M); k++) begin
      ax[k]     = {{N{ctrl_q[0].sgn & a1_q[k*N+N-1]}}, a1_q[k*N +: N]};
      bx[k]     = {{N{ctrl_q[0].sgn & b1[k*N+N-1]}}, b1[k*N +: N]};
      prod_d[k] = ax[k] * bx[k];
    end
  end

  // Product register stage.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < int'(M); k++) begin
      prod_q[k] <= prod_d[k];
    end
  end

  // Adder tree over the extended lane products.
  always_comb begin
    tree_d = '0;
    for (int k = 0; k < int'(M); k++) begin
      tree_d = tree_d + {{(TW-2*N){ctrl_q[1].sgn & prod_q[k][2*N-1]}}, prod_q[k]};
    end
  end

  // Tree sum register stage.
  always_ff @(posedge i_clk) begin
    tree_q <= tree_d;
  end

  // Accumulate, flag wraparound for the active mode, and form the result pulse.
  always_comb begin
    tree_ext = {{(S-TW){ctrl_q[2].sgn & tree_q[TW-1]}}, tree_q};
    add_full = {1'b0, acc_q} + {1'b0, tree_ext};
    add_ovf  = ctrl_q[2].sgn ? ((acc_q[S-1] == tree_ext[S-1]) && (add_full[S-1] != acc_q[S-1]))
                             : add_full[S];
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    valid_d  = ctrl_q[2].valid & ctrl_q[2].last;
    if (ctrl_q[2].valid) begin
      if (ctrl_q[2].first) begin
        acc_d = tree_ext;
        ovf_d = 1'b0;
      end else begin
        acc_d = add_full[S-1:0];
        ovf_d = ovf_q | add_ovf;
      end
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign dp.o_sum   = acc_q;
  assign dp.o_valid = valid_q;
  assign dp.o_ovf   = ovf_q;
  assign dp.o_err   = err_q;

endmodule
